// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles the two requester command/response channels and the single-port
//   memory bus that surround mem_arbiter.
//
//   Requester r0/r1 (N = 0/1):
//     rN_req, rN_wr, rN_addr, rN_wdata   command from requester
//     rN_gnt                             one-cycle grant pulse
//     rN_rdata, rN_rvalid                read data and its one-cycle strobe
//   Memory side:
//     mem_in_data, mem_address           write data / address to memory
//     mem_wr_en, mem_rd_en               memory strobes
//     mem_out_data, mem_valid_out        read data / valid from memory
//   Status:
//     err_timeout                        one-cycle pulse when a read is aborted
//
//   Modports:
//     slave  : the arbiter's view
//     master : the view of whatever drives the requesters and models memory
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int WIDTH   = 32,
    parameter int ADDRESS = 4
);
    logic               r0_req;
    logic               r0_wr;
    logic [ADDRESS-1:0] r0_addr;
    logic [WIDTH-1:0]   r0_wdata;
    logic               r0_gnt;
    logic [WIDTH-1:0]   r0_rdata;
    logic               r0_rvalid;

    logic               r1_req;
    logic               r1_wr;
    logic [ADDRESS-1:0] r1_addr;
    logic [WIDTH-1:0]   r1_wdata;
    logic               r1_gnt;
    logic [WIDTH-1:0]   r1_rdata;
    logic               r1_rvalid;

    logic [WIDTH-1:0]   mem_in_data;
    logic [ADDRESS-1:0] mem_address;
    logic               mem_wr_en;
    logic               mem_rd_en;
    logic [WIDTH-1:0]   mem_out_data;
    logic               mem_valid_out;

    logic               err_timeout;

    modport slave (
        input  r0_req, r0_wr, r0_addr, r0_wdata,
        input  r1_req, r1_wr, r1_addr, r1_wdata,
        input  mem_out_data, mem_valid_out,
        output r0_gnt, r0_rdata, r0_rvalid,
        output r1_gnt, r1_rdata, r1_rvalid,
        output mem_in_data, mem_address, mem_wr_en, mem_rd_en,
        output err_timeout
    );

    modport master (
        output r0_req, r0_wr, r0_addr, r0_wdata,
        output r1_req, r1_wr, r1_addr, r1_wdata,
        output mem_out_data, mem_valid_out,
        input  r0_gnt, r0_rdata, r0_rvalid,
        input  r1_gnt, r1_rdata, r1_rvalid,
        input  mem_in_data, mem_address, mem_wr_en, mem_rd_en,
        input  err_timeout
    );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Two-requester round-robin arbiter and sequencer in front of a single-port
//   memory. Commands from r0/r1 are serialised onto the memory port one at a
//   time; at most one read is outstanding and its data is routed back to the
//   requester that issued it. A read that sees no mem_valid_out within
//   TIMEOUT cycles is abandoned and err_timeout is pulsed.
//
//   Parameters:
//     WIDTH    data width
//     ADDRESS  address width (memory depth 2**ADDRESS)
//     TIMEOUT  cycles spent in WAIT_RD before a read is aborted (1..255)
//
//   Ports:
//     clk   single clock, all state on posedge
//     rst   asynchronous active-low reset
//     bus   mem_arbiter_if.slave: requester channels, memory bus, err_timeout
//
//   Every output is a flop. The grant, memory strobes, address and write data
//   are loaded on the edge that moves IDLE -> ISSUE, so they are visible for
//   exactly the ISSUE cycle and cleared on the edge that leaves it.
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int WIDTH   = 32,
    parameter int ADDRESS = 4,
    parameter int TIMEOUT = 8
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT_RD = 2'd2
    } state_t;

    // Value of the wait counter in the last WAIT_RD cycle before abort.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    // ---------------------------------------------------------------------
    // State and output registers
    // ---------------------------------------------------------------------
    state_t             r_state;
    logic [7:0]         r_cnt;
    logic               r_last_grant;   // 0 = r0, 1 = r1
    logic               r_owner;        // requester owning the pending read

    logic               r_mem_wr_en;
    logic               r_mem_rd_en;
    logic [ADDRESS-1:0] r_mem_address;
    logic [WIDTH-1:0]   r_mem_in_data;
    logic               r_r0_gnt;
    logic               r_r1_gnt;
    logic [WIDTH-1:0]   r_r0_rdata;
    logic [WIDTH-1:0]   r_r1_rdata;
    logic               r_r0_rvalid;
    logic               r_r1_rvalid;
    logic               r_err_timeout;

    // ---------------------------------------------------------------------
    // Next-state wires
    // ---------------------------------------------------------------------
    state_t             w_state_nxt;
    logic [7:0]         w_cnt_nxt;
    logic               w_last_grant_nxt;
    logic               w_owner_nxt;

    logic               w_mem_wr_en_nxt;
    logic               w_mem_rd_en_nxt;
    logic [ADDRESS-1:0] w_mem_address_nxt;
    logic [WIDTH-1:0]   w_mem_in_data_nxt;
    logic               w_r0_gnt_nxt;
    logic               w_r1_gnt_nxt;
    logic [WIDTH-1:0]   w_r0_rdata_nxt;
    logic [WIDTH-1:0]   w_r1_rdata_nxt;
    logic               w_r0_rvalid_nxt;
    logic               w_r1_rvalid_nxt;
    logic               w_err_timeout_nxt;

    // ---------------------------------------------------------------------
    // Arbitration: a lone request wins; on contention the requester that was
    // not granted last wins, so continuous contention strictly alternates.
    // ---------------------------------------------------------------------
    logic               w_any_req;
    logic               w_win_r1;
    logic               w_win_wr;
    logic [ADDRESS-1:0] w_win_addr;
    logic [WIDTH-1:0]   w_win_wdata;

    always_comb begin
        w_any_req   = bus.r0_req || bus.r1_req;
        w_win_r1    = bus.r1_req && (!bus.r0_req || !r_last_grant);
        w_win_wr    = w_win_r1 ? bus.r1_wr    : bus.r0_wr;
        w_win_addr  = w_win_r1 ? bus.r1_addr  : bus.r0_addr;
        w_win_wdata = w_win_r1 ? bus.r1_wdata : bus.r0_wdata;
    end

    // ---------------------------------------------------------------------
    // Next-state and next-output logic
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves one unassigned, which would otherwise infer a latch.
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_last_grant_nxt  = r_last_grant;
        w_owner_nxt       = r_owner;

        w_mem_wr_en_nxt   = 1'b0;
        w_mem_rd_en_nxt   = 1'b0;
        w_mem_address_nxt = '0;
        w_mem_in_data_nxt = '0;
        w_r0_gnt_nxt      = 1'b0;
        w_r1_gnt_nxt      = 1'b0;
        w_r0_rdata_nxt    = r_r0_rdata;
        w_r1_rdata_nxt    = r_r1_rdata;
        w_r0_rvalid_nxt   = 1'b0;
        w_r1_rvalid_nxt   = 1'b0;
        w_err_timeout_nxt = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_owner_nxt       = w_win_r1;
                    w_last_grant_nxt  = w_win_r1;
                    w_mem_wr_en_nxt   = w_win_wr;
                    w_mem_rd_en_nxt   = !w_win_wr;
                    w_mem_address_nxt = w_win_addr;
                    w_mem_in_data_nxt = w_win_wdata;
                    w_r0_gnt_nxt      = !w_win_r1;
                    w_r1_gnt_nxt      = w_win_r1;
                    w_state_nxt       = S_ISSUE;
                end
            end

            S_ISSUE: begin
                // The strobe register doubles as the latched command type.
                if (r_mem_rd_en) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_WAIT_RD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_WAIT_RD: begin
                // Valid is tested first so it wins over the final count.
                if (bus.mem_valid_out) begin
                    if (r_owner) begin
                        w_r1_rdata_nxt  = bus.mem_out_data;
                        w_r1_rvalid_nxt = 1'b1;
                    end else begin
                        w_r0_rdata_nxt  = bus.mem_out_data;
                        w_r0_rvalid_nxt = 1'b1;
                    end
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_err_timeout_nxt = 1'b1;
                    w_state_nxt       = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignments so every flop samples the values
        // from before this edge, independent of statement order.
        if (!rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_last_grant  <= 1'b1;      // r0 wins the first contention
            r_owner       <= 1'b0;
            r_mem_wr_en   <= 1'b0;
            r_mem_rd_en   <= 1'b0;
            r_mem_address <= '0;
            r_mem_in_data <= '0;
            r_r0_gnt      <= 1'b0;
            r_r1_gnt      <= 1'b0;
            r_r0_rdata    <= '0;
            r_r1_rdata    <= '0;
            r_r0_rvalid   <= 1'b0;
            r_r1_rvalid   <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_last_grant  <= w_last_grant_nxt;
            r_owner       <= w_owner_nxt;
            r_mem_wr_en   <= w_mem_wr_en_nxt;
            r_mem_rd_en   <= w_mem_rd_en_nxt;
            r_mem_address <= w_mem_address_nxt;
            r_mem_in_data <= w_mem_in_data_nxt;
            r_r0_gnt      <= w_r0_gnt_nxt;
            r_r1_gnt      <= w_r1_gnt_nxt;
            r_r0_rdata    <= w_r0_rdata_nxt;
            r_r1_rdata    <= w_r1_rdata_nxt;
            r_r0_rvalid   <= w_r0_rvalid_nxt;
            r_r1_rvalid   <= w_r1_rvalid_nxt;
            r_err_timeout <= w_err_timeout_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign bus.mem_wr_en   = r_mem_wr_en;
    assign bus.mem_rd_en   = r_mem_rd_en;
    assign bus.mem_address = r_mem_address;
    assign bus.mem_in_data = r_mem_in_data;
    assign bus.r0_gnt      = r_r0_gnt;
    assign bus.r1_gnt      = r_r1_gnt;
    assign bus.r0_rdata    = r_r0_rdata;
    assign bus.r1_rdata    = r_r1_rdata;
    assign bus.r0_rvalid   = r_r0_rvalid;
    assign bus.r1_rvalid   = r_r1_rvalid;
    assign bus.err_timeout = r_err_timeout;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter. The bench plays both requesters and
//   the memory. Expected grants and read results are pushed to scoreboard
//   queues when a command is driven and popped when the DUT responds.
//   Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int WIDTH   = 32;
    localparam int ADDRESS = 4;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.WIDTH(WIDTH), .ADDRESS(ADDRESS)) bus ();

    mem_arbiter #(
        .WIDTH   (WIDTH),
        .ADDRESS (ADDRESS),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Memory model: stores whatever the arbiter writes.
    logic [WIDTH-1:0] tb_mem [2**ADDRESS];

    always @(posedge clk) begin
        if (bus.mem_wr_en) tb_mem[bus.mem_address] <= bus.mem_in_data;
    end

    // Every DUT output concatenated, for all-zero checks.
    wire [3*WIDTH+ADDRESS+6:0] w_outs = {
        bus.r0_gnt, bus.r1_gnt, bus.r0_rvalid, bus.r1_rvalid,
        bus.r0_rdata, bus.r1_rdata, bus.mem_in_data, bus.mem_address,
        bus.mem_wr_en, bus.mem_rd_en, bus.err_timeout
    };

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic             id;
        logic [WIDTH-1:0] data;
    } rd_exp_t;

    rd_exp_t rd_q  [$];
    logic    gnt_q [$];
    logic    exp_last_grant;

    task automatic check(input logic ok, input string msg);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL %s", msg);
        end
    endtask

    // ---------------------------------------------------------------------
    // Stimulus helpers and reference model
    // ---------------------------------------------------------------------
    task automatic set_cmd(input int id, input logic req, input logic wr,
                           input logic [ADDRESS-1:0] addr,
                           input logic [WIDTH-1:0] wdata);
        if (id == 0) begin
            bus.r0_req = req; bus.r0_wr = wr; bus.r0_addr = addr; bus.r0_wdata = wdata;
        end else begin
            bus.r1_req = req; bus.r1_wr = wr; bus.r1_addr = addr; bus.r1_wdata = wdata;
        end
    endtask

    // Round-robin reference: predict the winner and push it.
    task automatic push_grant(input logic req0, input logic req1);
        logic w;
        w = (req0 && req1) ? !exp_last_grant : req1;
        gnt_q.push_back(w);
        exp_last_grant = w;
    endtask

    // Waits (bounded) for a grant; id = -1 on timeout, 2 if both granted.
    task automatic wait_grant(input int max_cycles, output int id, output int cycles);
        id     = -1;
        cycles = 0;
        for (int i = 1; i <= max_cycles; i++) begin
            @(negedge clk);
            if (bus.r0_gnt || bus.r1_gnt) begin
                id     = (bus.r0_gnt && bus.r1_gnt) ? 2 : (bus.r1_gnt ? 1 : 0);
                cycles = i;
                return;
            end
        end
    endtask

    // ---------------------------------------------------------------------
    // Scenarios
    // ---------------------------------------------------------------------
    task automatic test_reset();
        int got_id, cyc;
        logic exp_id;
        rst = 1'b0;
        set_cmd(0, 1'b1, 1'b1, 4'd3, 32'hA5A5_A5A5);
        set_cmd(1, 1'b1, 1'b1, 4'd2, 32'h0BAD_F00D);
        bus.mem_valid_out = 1'b0;
        bus.mem_out_data  = '0;
        repeat (2) @(negedge clk);
        check(w_outs === '0,
              $sformatf("reset_outputs: got %h, want all zero", w_outs));

        rst = 1'b1;
        exp_last_grant = 1'b1;
        push_grant(1'b1, 1'b1);
        wait_grant(4, got_id, cyc);
        exp_id = gnt_q.pop_front();
        check(got_id === int'(exp_id),
              $sformatf("first_grant: got %0d, want %0d", got_id, exp_id));
        check({bus.mem_wr_en, bus.mem_rd_en, bus.mem_address, bus.mem_in_data} ===
              {1'b1, 1'b0, 4'd3, 32'hA5A5_A5A5},
              $sformatf("first_write_bus: got wr=%b rd=%b addr=%0d data=%h, want wr=1 rd=0 addr=3 data=a5a5a5a5",
                        bus.mem_wr_en, bus.mem_rd_en, bus.mem_address, bus.mem_in_data));
        set_cmd(0, 1'b0, 1'b0, '0, '0);
        set_cmd(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check({bus.mem_wr_en, bus.r0_gnt, bus.r1_gnt} === 3'b000,
              $sformatf("write_one_cycle: got wr=%b g0=%b g1=%b, want 0 0 0",
                        bus.mem_wr_en, bus.r0_gnt, bus.r1_gnt));
    endtask

    task automatic test_contention();
        int got_id, cyc;
        logic exp_id;
        set_cmd(0, 1'b1, 1'b1, 4'd1, 32'h1111_1111);
        set_cmd(1, 1'b1, 1'b1, 4'd2, 32'h2222_2222);
        for (int k = 0; k < 8; k++) push_grant(1'b1, 1'b1);
        for (int k = 0; k < 8; k++) begin
            wait_grant(4, got_id, cyc);
            exp_id = gnt_q.pop_front();
            check(got_id === int'(exp_id),
                  $sformatf("contention_grant[%0d]: got %0d, want %0d", k, got_id, exp_id));
            check({bus.mem_wr_en, bus.mem_address} === {1'b1, (exp_id ? 4'd2 : 4'd1)},
                  $sformatf("contention_bus[%0d]: got wr=%b addr=%0d, want wr=1 addr=%0d",
                            k, bus.mem_wr_en, bus.mem_address, exp_id ? 2 : 1));
            if (k > 0)
                check(cyc === 2,
                      $sformatf("contention_spacing[%0d]: got %0d cycles, want 2", k, cyc));
        end
        set_cmd(0, 1'b0, 1'b0, '0, '0);
        set_cmd(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
    endtask

    // Read with a memory response one cycle after mem_rd_en.
    task automatic read_lat1(input logic id, input logic [ADDRESS-1:0] addr,
                             input logic [WIDTH-1:0] exp_data,
                             input logic [WIDTH-1:0] exp_other_rdata);
        int got_id, cyc;
        logic exp_id;
        rd_exp_t e;
        set_cmd(int'(id), 1'b1, 1'b0, addr, '0);
        push_grant(!id, id);
        wait_grant(4, got_id, cyc);
        exp_id = gnt_q.pop_front();
        check(got_id === int'(exp_id),
              $sformatf("read_grant: got %0d, want %0d", got_id, exp_id));
        check({bus.mem_rd_en, bus.mem_wr_en, bus.mem_address} === {1'b1, 1'b0, addr},
              $sformatf("read_bus: got rd=%b wr=%b addr=%0d, want rd=1 wr=0 addr=%0d",
                        bus.mem_rd_en, bus.mem_wr_en, bus.mem_address, addr));
        rd_q.push_back('{id: id, data: exp_data});
        set_cmd(int'(id), 1'b0, 1'b0, '0, '0);

        @(negedge clk);
        bus.mem_valid_out = 1'b1;
        bus.mem_out_data  = tb_mem[addr];
        @(negedge clk);
        bus.mem_valid_out = 1'b0;
        bus.mem_out_data  = '0;

        e = rd_q.pop_front();
        check((e.id ? bus.r1_rvalid : bus.r0_rvalid) === 1'b1,
              $sformatf("read_rvalid: got 0, want 1 on r%0d", e.id));
        check((e.id ? bus.r1_rdata : bus.r0_rdata) === e.data,
              $sformatf("read_rdata: got %h, want %h",
                        e.id ? bus.r1_rdata : bus.r0_rdata, e.data));
        check({(e.id ? bus.r0_rvalid : bus.r1_rvalid), (e.id ? bus.r0_rdata : bus.r1_rdata)} ===
              {1'b0, exp_other_rdata},
              $sformatf("read_other_side: got rvalid=%b rdata=%h, want 0 %h",
                        e.id ? bus.r0_rvalid : bus.r1_rvalid,
                        e.id ? bus.r0_rdata : bus.r1_rdata, exp_other_rdata));
        @(negedge clk);
        check({(e.id ? bus.r1_rvalid : bus.r0_rvalid), (e.id ? bus.r1_rdata : bus.r0_rdata),
               bus.mem_rd_en} === {1'b0, e.data, 1'b0},
              $sformatf("read_pulse_hold: got rvalid=%b rdata=%h rd=%b, want 0 %h 0",
                        e.id ? bus.r1_rvalid : bus.r0_rvalid,
                        e.id ? bus.r1_rdata : bus.r0_rdata, bus.mem_rd_en, e.data));
    endtask

    task automatic test_read_r1();
        read_lat1(1'b1, 4'd3, 32'hA5A5_A5A5, 32'h0);
    endtask

    task automatic test_timeout();
        int got_id, cyc, err_at, err_pulses;
        logic exp_id, saw_rv;
        set_cmd(0, 1'b1, 1'b0, 4'd5, '0);
        push_grant(1'b1, 1'b0);
        wait_grant(4, got_id, cyc);
        exp_id = gnt_q.pop_front();
        check(got_id === int'(exp_id) && bus.mem_rd_en === 1'b1,
              $sformatf("timeout_grant: got id=%0d rd=%b, want id=%0d rd=1",
                        got_id, bus.mem_rd_en, exp_id));
        set_cmd(0, 1'b0, 1'b0, '0, '0);

        err_at = -1; err_pulses = 0; saw_rv = 1'b0;
        for (int i = 1; i <= TIMEOUT + 4; i++) begin
            @(negedge clk);
            if (bus.r0_rvalid || bus.r1_rvalid) saw_rv = 1'b1;
            if (bus.err_timeout) begin
                err_pulses++;
                if (err_at < 0) err_at = i;
            end
        end
        check(err_at === TIMEOUT + 1,
              $sformatf("timeout_when: got cycle %0d, want %0d", err_at, TIMEOUT + 1));
        check(err_pulses === 1,
              $sformatf("timeout_pulses: got %0d, want 1", err_pulses));
        check(saw_rv === 1'b0 && bus.r0_rdata === 32'h0,
              $sformatf("timeout_no_rvalid: got rvalid_seen=%b r0_rdata=%h, want 0 0",
                        saw_rv, bus.r0_rdata));

        set_cmd(1, 1'b1, 1'b1, 4'd7, 32'h7777_7777);
        push_grant(1'b0, 1'b1);
        wait_grant(4, got_id, cyc);
        exp_id = gnt_q.pop_front();
        check(got_id === int'(exp_id) && bus.mem_wr_en === 1'b1,
              $sformatf("after_timeout_grant: got id=%0d wr=%b, want id=%0d wr=1",
                        got_id, bus.mem_wr_en, exp_id));
        set_cmd(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
    endtask

    // Valid arrives in the very cycle the counter hits its last value.
    task automatic test_valid_at_deadline();
        int got_id, cyc, rv_at;
        logic exp_id, saw_err;
        rd_exp_t e;
        set_cmd(1, 1'b1, 1'b0, 4'd1, '0);
        push_grant(1'b0, 1'b1);
        wait_grant(4, got_id, cyc);
        exp_id = gnt_q.pop_front();
        check(got_id === int'(exp_id),
              $sformatf("deadline_grant: got %0d, want %0d", got_id, exp_id));
        rd_q.push_back('{id: 1'b1, data: 32'h1111_1111});
        set_cmd(1, 1'b0, 1'b0, '0, '0);

        rv_at = -1; saw_err = 1'b0;
        for (int i = 1; i <= TIMEOUT + 3; i++) begin
            @(negedge clk);
            if (bus.err_timeout) saw_err = 1'b1;
            if (bus.r1_rvalid && rv_at < 0) begin
                rv_at = i;
                e = rd_q.pop_front();
                check(bus.r1_rdata === e.data,
                      $sformatf("deadline_rdata: got %h, want %h", bus.r1_rdata, e.data));
            end
            bus.mem_valid_out = (i == TIMEOUT);
            bus.mem_out_data  = (i == TIMEOUT) ? tb_mem[1] : '0;
        end
        check(rv_at === TIMEOUT + 1 && saw_err === 1'b0,
              $sformatf("deadline_valid_wins: got rvalid_cycle=%0d err=%b, want %0d 0",
                        rv_at, saw_err, TIMEOUT + 1));
    endtask

    task automatic test_reset_mid_read();
        int got_id, cyc;
        logic exp_id, saw_rv;
        set_cmd(1, 1'b1, 1'b0, 4'd4, '0);
        push_grant(1'b0, 1'b1);
        wait_grant(4, got_id, cyc);
        exp_id = gnt_q.pop_front();
        check(got_id === int'(exp_id),
              $sformatf("midreset_grant: got %0d, want %0d", got_id, exp_id));
        set_cmd(1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check(w_outs === '0,
              $sformatf("midreset_async_clear: got %h, want all zero", w_outs));
        exp_last_grant = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus.mem_valid_out = 1'b1;
        bus.mem_out_data  = 32'h0000_BEEF;
        saw_rv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.mem_valid_out = 1'b0;
            bus.mem_out_data  = '0;
            if (bus.r0_rvalid || bus.r1_rvalid) saw_rv = 1'b1;
        end
        check({saw_rv, bus.r0_rdata, bus.r1_rdata} === {1'b0, 32'h0, 32'h0},
              $sformatf("midreset_late_valid: got rvalid_seen=%b r0=%h r1=%h, want 0 0 0",
                        saw_rv, bus.r0_rdata, bus.r1_rdata));
    endtask

    task automatic test_spurious_valid();
        logic saw_rv;
        read_lat1(1'b0, 4'd2, 32'h2222_2222, 32'h0);
        bus.mem_valid_out = 1'b1;
        bus.mem_out_data  = 32'h0000_DEAD;
        saw_rv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.r0_rvalid || bus.r1_rvalid || bus.mem_rd_en) saw_rv = 1'b1;
        end
        bus.mem_valid_out = 1'b0;
        bus.mem_out_data  = '0;
        @(negedge clk);
        check(saw_rv === 1'b0, "spurious_rvalid: got activity=1, want 0");
        check({bus.r0_rdata, bus.r1_rdata} === {32'h2222_2222, 32'h0},
              $sformatf("spurious_rdata: got r0=%h r1=%h, want 22222222 00000000",
                        bus.r0_rdata, bus.r1_rdata));
    endtask

    // ---------------------------------------------------------------------
    // Sequence
    // ---------------------------------------------------------------------
    initial begin
        test_reset();
        test_contention();
        test_read_r1();
        test_timeout();
        test_valid_at_deadline();
        test_reset_mid_read();
        test_spurious_valid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the single-port memory (WIDTH-bit data, ADDRESS-bit address, wr_en/rd_en in, out_data/valid_out back).
- Serialises write and read commands from requesters r0/r1 onto the memory port.
- Tracks the single outstanding read and routes out_data/valid_out to the requester that issued it.
- Flags reads that get no response within a bounded time.

Parameters:
- WIDTH, 32, data width of memory and requester data buses
- ADDRESS, 4, address width (DEPTH = 2**ADDRESS words)
- TIMEOUT, 8, max cycles in WAIT_RD without mem_valid_out before abort; legal range 1..255

Ports:
- clk  in  1  single clock, all state on posedge
- rst  in  1  asynchronous, active-low reset
- r0_req  in  1  r0 command request, held until r0_gnt seen
- r0_wr  in  1  r0 command type: 1=write, 0=read
- r0_addr  in  ADDRESS  r0 address
- r0_wdata  in  WIDTH  r0 write data
- r0_gnt  out  1  one-cycle grant pulse to r0
- r0_rdata  out  WIDTH  read data returned to r0
- r0_rvalid  out  1  one-cycle pulse, r0_rdata valid
- r1_req, r1_wr, r1_addr, r1_wdata, r1_gnt, r1_rdata, r1_rvalid: same as r0 for requester 1
- mem_in_data  out  WIDTH  memory write data
- mem_address  out  ADDRESS  memory address
- mem_wr_en  out  1  memory write strobe
- mem_rd_en  out  1  memory read strobe
- mem_out_data  in  WIDTH  memory read data
- mem_valid_out  in  1  memory read-data valid
- err_timeout  out  1  one-cycle pulse on read abort

Behaviour:
- Reset (rst=0, async): all outputs 0, FSM=IDLE, wait counter=0, last_grant=1 (r0 wins first contention). An in-flight read is discarded and no rvalid is produced for it.
- FSM states: IDLE, ISSUE, WAIT_RD. All outputs are registered.
- IDLE:
  - Req sampling occurs only in IDLE.
  - If exactly one req is high, it wins.
  - If both are high, the requester != last_grant wins.
  - On a winner: latch its wr/addr/wdata and the winner id, set last_grant=winner, go to ISSUE.
  - With no req: stay in IDLE, outputs 0.
- ISSUE (exactly 1 cycle):
  - Assert mem_wr_en=wr or mem_rd_en=!wr, with mem_address/mem_in_data from the latch.
  - Assert the winner's gnt=1 for this cycle only.
  - Next state: write -> IDLE; read -> WAIT_RD with counter=0.
- Requester rule: deassert or change req/command at the edge ending its gnt cycle. A req still high after that is treated as a new command.
- WAIT_RD:
  - mem_wr_en and mem_rd_en are 0.
  - Each cycle with mem_valid_out=0: counter++.
  - If mem_valid_out=1: capture mem_out_data into the owner's rdata, pulse the owner's rvalid next cycle, go to IDLE.
  - If counter reaches TIMEOUT-1 with no valid: pulse err_timeout next cycle, no rvalid, go to IDLE.
  - Valid and the final count on the same cycle: valid wins.
- mem_valid_out outside WAIT_RD is ignored; no rvalid is generated.
- rdata holds its last captured value until overwritten. The non-owner's rdata/rvalid are unchanged.
- Throughput: a write takes 2 cycles (IDLE+ISSUE). A read takes 2 + response latency + 1.
- No starvation: under continuous contention, grants strictly alternate.

Test Plan:
- Reset with both req high, release rst -> first gnt to r0; r0 write addr 3 data 0xA5A5A5A5 -> mem_wr_en=1, mem_address=3, mem_in_data=0xA5A5A5A5 for exactly 1 cycle with r0_gnt=1.
- r0 and r1 both continuously request writes (addr 1, 2) for 8 grants -> grants alternate r0,r1,r0,r1...; r1 is never granted twice in a row.
- r1 read addr 3, memory returns 0xA5A5A5A5 with valid_out 1 cycle after rd_en -> r1_rvalid pulse 1 cycle, r1_rdata=0xA5A5A5A5, r0_rvalid stays 0, then back to IDLE.
- r0 read, memory never asserts valid_out, TIMEOUT=8 -> err_timeout pulses once 8 cycles after ISSUE, no r0_rvalid, next req is granted normally.
- rst=0 asserted mid-WAIT_RD for r1 -> all outputs 0 immediately (async); after release, a late mem_valid_out produces no rvalid.
- Spurious mem_valid_out=1 in IDLE with data 0xDEAD -> no rvalid and no rdata change on either requester.
